// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC result drain stage.
// Lane geometry, quantisation limits and the drain FSM encoding live here.
package mac_pkg;

    localparam int LANES  = 16;
    localparam int ACC_W  = 17;
    localparam int Q_W    = 8;
    localparam int SH_W   = 4;
    localparam int LANE_W = $clog2(LANES);

    localparam int Q_MAX = 127;
    localparam int Q_MIN = -128;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    typedef logic [LANE_W-1:0] laneIdx_t;

    localparam laneIdx_t LAST_LANE = laneIdx_t'(LANES - 1);

endpackage

// File: rtl/requant_lane.sv
// Combinational requantiser for one accumulator lane:
// round-half-up, arithmetic right shift, optional ReLU, saturate to Q_W bits.
module requant_lane
    import mac_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [SH_W-1:0]  shift,
    input  logic             relu,
    output logic [Q_W-1:0]   q
);

    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W + 1)'(Q_MAX);
    localparam logic signed [ACC_W:0] SAT_LO = (ACC_W + 1)'(Q_MIN);

    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;

    // One extra bit of headroom keeps x + rounding constant from overflowing.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        rnd = '0;
        if (shift != '0) begin
            rnd = (ACC_W + 1)'(1) << (shift - 1'b1);
        end
        sum     = $signed({acc[ACC_W-1], acc}) + rnd;
        shifted = sum >>> shift;
        if (relu && shifted[ACC_W]) begin
            shifted = '0;
        end

        q = shifted[Q_W-1:0];
        if (shifted > SAT_HI) begin
            q = SAT_HI[Q_W-1:0];
        end else if (shifted < SAT_LO) begin
            q = SAT_LO[Q_W-1:0];
        end
    end

endmodule

// File: rtl/mac_result_drain.sv
// Captures one 16-lane accumulator block and streams requantised lanes out
// one per cycle on valid/ready; single-buffered, stalls on back-pressure.
module mac_result_drain
    import mac_pkg::*;
(
    input  logic                   Clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*ACC_W-1:0] in_data,
    input  logic [SH_W-1:0]        shift_amt,
    input  logic                   relu_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [Q_W-1:0]         out_data,
    output laneIdx_t               out_lane,
    output logic                   out_last,
    output logic                   busy
);

    state_t   state;
    state_t   nextState;
    laneIdx_t cnt;

    logic [LANES-1:0][ACC_W-1:0] bank;
    logic [SH_W-1:0]             shReg;
    logic                        reluReg;

    logic           outValid;
    logic [Q_W-1:0] outData;
    laneIdx_t       outLane;
    logic           outLast;

    logic           capture;
    logic           load;
    logic [Q_W-1:0] laneQ;

    requant_lane uRequant (
        .acc   (bank[cnt]),
        .shift (shReg),
        .relu  (reluReg),
        .q     (laneQ)
    );

    // in_ready is gated by reset so it reads low throughout any reset cycle.
    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        capture   = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !reset;
                if (in_valid && !reset) begin
                    capture   = 1'b1;
                    nextState = DRAIN;
                end
            end
            DRAIN: begin
                load = !outValid || out_ready;
                if (load && cnt == LAST_LANE) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            // NOTE: the capture bank is cleared on reset so no stale block can ever be drained.
            bank     <= '0;
            shReg    <= '0;
            reluReg  <= 1'b0;
            cnt      <= '0;
            outValid <= 1'b0;
            outData  <= '0;
            outLane  <= '0;
            outLast  <= 1'b0;
        end else begin
            if (capture) begin
                bank    <= in_data;
                shReg   <= shift_amt;
                reluReg <= relu_en;
                cnt     <= '0;
            end
            if (load) begin
                outValid <= 1'b1;
                outData  <= laneQ;
                outLane  <= cnt;
                outLast  <= (cnt == LAST_LANE);
                cnt      <= cnt + 1'b1;
            end else if (outValid && out_ready) begin
                outValid <= 1'b0;
            end
        end
    end

    assign out_valid = outValid;
    assign out_data  = outData;
    assign out_lane  = outLane;
    assign out_last  = outLast;
    assign busy      = (state != IDLE) || outValid;

endmodule

// File: doc/mac_result_drain.md
Name: mac_result_drain

Overview:
Downstream stage of the 16-lane MAC array output register. It captures one 16-lane block of signed 17-bit accumulator results and requantises each lane to signed 8-bit: round, arithmetic shift, optional ReLU, saturate. It then streams the lanes out one per cycle on a valid/ready interface toward the activation buffer / next-layer data input. It is a single-buffered block and stalls on back-pressure.

Parameters:
LANES, 16, number of result lanes per block.
ACC_W, 17, signed accumulator width per lane.
Q_W, 8, signed output width.
SH_W, 4, width of the shift-amount field.

Ports:
Clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  result block valid; asserted in the cycle after the MAC core's COMP pulse.
in_ready  out  1  block can be accepted (high only in IDLE).
in_data  in  LANES*ACC_W  packed results; lane n at [n*ACC_W +: ACC_W], two's complement.
shift_amt  in  SH_W  right-shift amount, 0..15; sampled with the block.
relu_en  in  1  clamp negatives to 0; sampled with the block.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts.
out_data  out  Q_W  requantised lane value, signed.
out_lane  out  $clog2(LANES)  lane index of out_data.
out_last  out  1  high with lane LANES-1.
busy  out  1  state != IDLE or out_valid.

Behaviour:
- One clock domain, Clk.
- Synchronous active-high reset. Reset values:
  - state=IDLE, lane counter=0, captured bank=0.
  - out_valid=0, out_data=0, out_lane=0, out_last=0, busy=0.
  - in_ready=0 during the reset cycle; in_ready=1 from the first cycle after reset deasserts.
- Reset mid-drain discards the remaining lanes. No partial output after reset.
- FSM has two states: IDLE and DRAIN.
  - IDLE: in_ready=1. On in_valid=1, capture in_data, shift_amt and relu_en into internal registers, clear the lane counter, and go to DRAIN.
  - DRAIN: in_ready=0. The output register loads lane[cnt] when (!out_valid || out_ready); cnt then increments.
  - When lane LANES-1 has been loaded, return to IDLE. out_valid stays high until that beat is accepted.
- in_valid while in_ready=0 is ignored. The upstream source must hold in_valid.
- Output register hold rule: while out_valid && !out_ready, out_data, out_lane and out_last are held stable.
- out_valid drops after the last beat is accepted unless a new load occurs in the same cycle.
- Latency: block accepted in cycle c → lane 0 out_valid in cycle c+2.
- With out_ready held high:
  - one lane per cycle; lanes 0..15 appear in cycles c+2..c+17;
  - the next block can be accepted from cycle c+17 (in_ready back high).
- A new block accepted in IDLE while the final beat is still held (out_valid=1, out_ready=0) is legal. Its lane 0 loads only once that beat is accepted.
- Per-lane arithmetic (sh = captured shift_amt):
  - r = (sh==0) ? 0 : 1<<(sh-1).
  - t = (x + r) computed at ACC_W+1 bits, sign-extended, so there is no overflow.
  - y = t >>> sh (arithmetic shift).
  - If relu_en and y<0, then y=0.
  - Saturate y to [-128, 127].
  - The result is round-half-up toward +inf.
- The captured shift_amt and relu_en apply to all 16 lanes of a block, even if the inputs change during the drain.

Decomposition:
- Shared package mac_pkg holds:
  - LANES, ACC_W, Q_W, SH_W constants;
  - the FSM state enum (IDLE, DRAIN);
  - the lane-index typedef;
  - Q_MAX=127 and Q_MIN=-128.
- One sub-module, requant_lane: a purely combinational round/shift/ReLU/saturate on one lane. It is instantiated once on the lane mux output, not once per lane.
- The FSM, capture bank and output register stay in mac_result_drain.

Test Plan:
- Basic requantisation: shift=4, relu=0, lane0=100, lane1=-100, other lanes 0, out_ready=1 → out_data 6, -6, then 0×14. Lanes 0..15 in consecutive cycles; out_last on lane 15; in_ready high again 17 cycles after acceptance.
- ReLU and rounding: shift=8, relu=1, lanes {200, -200, 127, 128} → 1, 0, 0, 1.
- Saturation: shift=0, lane0=65535, lane1=-65536, lane2=127, lane3=-129 → 127, -128, 127, -128.
- Back-pressure: toggle out_ready 1,0,0,1 per cycle → no lane dropped or duplicated; out_data/out_lane stable while stalled; in_valid during DRAIN is ignored and the block is accepted only after return to IDLE.
- Reset mid-drain: assert reset after lane 5 is accepted → next cycle out_valid=0, in_ready=0, busy=0. in_ready=1 the cycle after reset deasserts. The next block starts at lane 0 with new values.
- Config sampling: shift_amt changes from 2 to 0 during a drain with all lanes=7 → all 16 outputs equal 2 ((7+2)>>2).
